// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the player-ID ROM arbiter.
// Holds the FSM encoding, default geometry and the end-of-table marker.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_CATCH = 2'd3
    } arb_state_e;

    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 16;
    localparam int ROM_LAT_DEF = 2;

    // Terminates every table stored in the ID ROM.
    localparam logic [15:0] ROM_EOT_MARK = 16'hFFFF;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rom_arbiter_rr_picker.sv
// Combinational round-robin selector: first set req bit searching upward
// from last+1 (mod N_REQ); returns the winner one-hot and as an index.
module rr_picker
    import rom_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_REQ-1:0] win_oh_o,
    output logic [IDX_W-1:0] win_idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_i) + k) % N_REQ);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                win_oh_o[cand] = 1'b1;
                win_idx_o      = cand;
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter in front of the synchronous player-ID ROM.
// Optional burst locking is enabled by defining ROM_ARB_LOCK_EN.
//
// state   | meaning
// IDLE    | no read in flight; samples req and picks a winner
// ISSUE   | drives the latched address onto ROM_addr
// WAIT    | counts out the ROM read latency
// CATCH   | captures ROM_data, pulses rd_valid to the winner
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ-1:0]        lock,
    output logic [N_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]       rd_data,
    output logic [N_REQ-1:0]        rd_valid,
    output logic [ADDR_W-1:0]       ROM_addr,
    input  logic [DATA_W-1:0]       ROM_data,
    output logic                    busy
);

    localparam int IDX_W = idx_w(N_REQ);
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_LAT - 1);

    arb_state_e        state_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [N_REQ-1:0]  rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  last_q;
    logic [IDX_W-1:0]  win_idx_q;
    logic              busy_q;

    logic [N_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  addr_sel;
    logic [ADDR_W-1:0] addr_d;
    logic              hold_lock;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i     (req),
        .last_i    (last_q),
        .win_oh_o  (pick_oh),
        .win_idx_o (pick_idx)
    );

    // IDLE latches the new winner's address; CATCH re-latches the current one.
    assign addr_sel = (state_q == S_IDLE) ? pick_idx : win_idx_q;
    assign addr_d   = req_addr[int'(addr_sel)*ADDR_W +: ADDR_W];

`ifdef ROM_ARB_LOCK_EN
    assign hold_lock = lock[win_idx_q] & req[win_idx_q];
`else
    logic unused_lock;
    assign hold_lock   = 1'b0;
    assign unused_lock = ^lock;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            rom_addr_q <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            last_q     <= IDX_W'(N_REQ - 1);
            win_idx_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            rd_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        gnt_q     <= pick_oh;
                        win_idx_q <= pick_idx;
                        addr_q    <= addr_d;
                        busy_q    <= 1'b1;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rom_addr_q <= addr_q;
                    cnt_q      <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_CATCH;
                    end
                end
                S_CATCH: begin
                    rd_data_q  <= ROM_data;
                    rd_valid_q <= gnt_q;
                    if (hold_lock) begin
                        // Locked burst: keep the grant and pointer, skip IDLE.
                        addr_q  <= addr_d;
                        state_q <= S_ISSUE;
                    end else begin
                        last_q  <= win_idx_q;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign ROM_addr = rom_addr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus randomized
// transactions predicted by a transaction-level round-robin model.
module tb_rom_arbiter;

    localparam int N_REQ   = 2;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 16;
    localparam int ROM_LAT = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ-1:0]        lock = '0;
    logic [N_REQ*ADDR_W-1:0] req_addr = '0;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]       rd_data;
    logic [ADDR_W-1:0]       ROM_addr;
    logic [DATA_W-1:0]       ROM_data;
    logic [DATA_W-1:0]       rom_q = '0;
    logic                    busy;

    logic [DATA_W-1:0] rom_mem [0:(1<<ADDR_W)-1];

    int errors = 0;
    int checks = 0;
    int m_last = N_REQ - 1;

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency (within ROM_LAT).
    always @(posedge clk) rom_q <= rom_mem[ROM_addr];
    assign ROM_data = rom_q;

    rom_arbiter #(
        .N_REQ   (N_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .lock     (lock),
        .gnt      (gnt),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .ROM_addr (ROM_addr),
        .ROM_data (ROM_data),
        .busy     (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N_REQ-1:0] r, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int i);
        return req_addr[i*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input int i);
        logic [N_REQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic rand_addrs();
        for (int i = 0; i < N_REQ; i++)
            req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, (1<<ADDR_W)-1));
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        req  = '0;
        lock = '0;
        step();
        step();
        rst    = 1'b1;
        m_last = N_REQ - 1;
        step();
    endtask

    task automatic test_reset();
        checks++; if (gnt !== '0)      begin errors++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
        checks++; if (rd_valid !== '0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rd_data !== '0)  begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        checks++; if (ROM_addr !== '0) begin errors++; $display("FAIL reset_rom_addr: got %0d expected 0", ROM_addr); end
    endtask

    task automatic test_single();
        rom_mem[5] = 16'h1234;
        req_addr = '0;
        req_addr[0 +: ADDR_W] = 5'd5;
        req = 2'b01;
        step();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b expected 01", gnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hi: got %b expected 1", busy); end
        step();
        checks++; if (ROM_addr !== 5'd5) begin errors++; $display("FAIL single_rom_addr: got %0d expected 5", ROM_addr); end
        step();
        step();
        checks++; if (rd_valid !== '0) begin errors++; $display("FAIL single_early_valid: got %b expected 00", rd_valid); end
        step();
        checks++; if (rd_valid !== 2'b01) begin errors++; $display("FAIL single_rd_valid: got %b expected 01", rd_valid); end
        checks++; if (rd_data !== 16'h1234) begin errors++; $display("FAIL single_rd_data: got %h expected 1234", rd_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_lo: got %b expected 0", busy); end
        checks++; if (gnt !== '0) begin errors++; $display("FAIL single_gnt_drop: got %b expected 00", gnt); end
        req = '0;
        m_last = 0;
        step();
        checks++; if (rd_valid !== '0) begin errors++; $display("FAIL single_valid_width: got %b expected 00", rd_valid); end
    endtask

    task automatic test_round_robin();
        int w;
        logic [ADDR_W-1:0] a;
        do_reset();
        req = '1;
        for (int t = 0; t < 6; t++) begin
            rand_addrs();
            w = pick(req, m_last);
            a = addr_of(w);
            step();
            checks++; if (gnt !== onehot(w)) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", t, gnt, onehot(w)); end
            step();
            checks++; if (ROM_addr !== a) begin errors++; $display("FAIL rr_rom_addr[%0d]: got %0d expected %0d", t, ROM_addr, a); end
            step();
            step();
            checks++; if (rd_valid !== '0) begin errors++; $display("FAIL rr_early_valid[%0d]: got %b expected 00", t, rd_valid); end
            step();
            checks++; if (rd_valid !== onehot(w)) begin errors++; $display("FAIL rr_rd_valid[%0d]: got %b expected %b", t, rd_valid, onehot(w)); end
            checks++; if (rd_data !== rom_mem[a]) begin errors++; $display("FAIL rr_rd_data[%0d]: got %h expected %h", t, rd_data, rom_mem[a]); end
            m_last = w;
        end
        req = '0;
        step();
    endtask

    task automatic test_drop();
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] a0;
        rand_addrs();
        a  = addr_of(1);
        a0 = addr_of(0);
        req = 2'b10;
        step();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL drop_gnt: got %b expected 10", gnt); end
        step();
        req = 2'b01;
        step();
        step();
        step();
        checks++; if (rd_valid !== 2'b10) begin errors++; $display("FAIL drop_rd_valid: got %b expected 10", rd_valid); end
        checks++; if (rd_data !== rom_mem[a]) begin errors++; $display("FAIL drop_rd_data: got %h expected %h", rd_data, rom_mem[a]); end
        step();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL drop_next_gnt: got %b expected 01", gnt); end
        step();
        step();
        step();
        step();
        checks++; if (rd_valid !== 2'b01) begin errors++; $display("FAIL drop_next_valid: got %b expected 01", rd_valid); end
        checks++; if (rd_data !== rom_mem[a0]) begin errors++; $display("FAIL drop_next_data: got %h expected %h", rd_data, rom_mem[a0]); end
        req = '0;
        m_last = 0;
        step();
    endtask

    task automatic test_random();
        int w;
        logic [N_REQ-1:0] r;
        logic [ADDR_W-1:0] a;
        for (int t = 0; t < 30; t++) begin
            rand_addrs();
            r = N_REQ'($urandom_range(0, (1<<N_REQ)-1));
`ifdef ROM_ARB_LOCK_EN
            lock = '0;
`else
            lock = N_REQ'($urandom);
`endif
            req = r;
            if (r == '0) begin
                step();
                step();
                checks++; if (gnt !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rand_idle[%0d]: got gnt=%b busy=%b expected 0/0", t, gnt, busy); end
                continue;
            end
            w = pick(r, m_last);
            a = addr_of(w);
            step();
            checks++; if (gnt !== onehot(w)) begin errors++; $display("FAIL rand_gnt[%0d]: got %b expected %b", t, gnt, onehot(w)); end
            rand_addrs();
            if ($urandom_range(0, 1) == 1) req = req & N_REQ'($urandom);
            step();
            checks++; if (ROM_addr !== a) begin errors++; $display("FAIL rand_rom_addr[%0d]: got %0d expected %0d", t, ROM_addr, a); end
            step();
            step();
            checks++; if (rd_valid !== '0) begin errors++; $display("FAIL rand_early_valid[%0d]: got %b expected 00", t, rd_valid); end
            step();
            checks++; if (rd_valid !== onehot(w)) begin errors++; $display("FAIL rand_rd_valid[%0d]: got %b expected %b", t, rd_valid, onehot(w)); end
            checks++; if (rd_data !== rom_mem[a]) begin errors++; $display("FAIL rand_rd_data[%0d]: got %h expected %h", t, rd_data, rom_mem[a]); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_busy[%0d]: got %b expected 0", t, busy); end
            m_last = w;
        end
        req  = '0;
        lock = '0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [ADDR_W-1:0] a0;
        rand_addrs();
        req = 2'b10;
        step();
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (gnt !== '0)      begin errors++; $display("FAIL rmid_gnt: got %b expected 00", gnt); end
        checks++; if (rd_valid !== '0) begin errors++; $display("FAIL rmid_rd_valid: got %b expected 00", rd_valid); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (ROM_addr !== '0) begin errors++; $display("FAIL rmid_rom_addr: got %0d expected 0", ROM_addr); end
        checks++; if (rd_data !== '0)  begin errors++; $display("FAIL rmid_rd_data: got %h expected 0", rd_data); end
        step();
        rst    = 1'b1;
        m_last = N_REQ - 1;
        req    = '1;
        a0     = addr_of(0);
        step();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rmid_first_gnt: got %b expected 01", gnt); end
        step();
        step();
        step();
        checks++; if (rd_valid !== '0) begin errors++; $display("FAIL rmid_stale_valid: got %b expected 00", rd_valid); end
        step();
        checks++; if (rd_valid !== 2'b01) begin errors++; $display("FAIL rmid_rd_valid_after: got %b expected 01", rd_valid); end
        checks++; if (rd_data !== rom_mem[a0]) begin errors++; $display("FAIL rmid_rd_data_after: got %h expected %h", rd_data, rom_mem[a0]); end
        req = '0;
        m_last = 0;
        step();
    endtask

    task automatic test_lock();
        int exp_w [5];
        int exp_gap [4];
        int npulse;
        int n0;
        int last_c;
        logic [DATA_W-1:0] exp_d;
        do_reset();
`ifdef ROM_ARB_LOCK_EN
        exp_w   = '{0, 0, 0, 0, 1};
        exp_gap = '{2 + ROM_LAT, 2 + ROM_LAT, 2 + ROM_LAT, 3 + ROM_LAT};
`else
        exp_w   = '{0, 1, 0, 1, 0};
        exp_gap = '{3 + ROM_LAT, 3 + ROM_LAT, 3 + ROM_LAT, 3 + ROM_LAT};
`endif
        req_addr = '0;
        req_addr[ADDR_W +: ADDR_W] = 5'd20;
        lock   = 2'b01;
        req    = '1;
        npulse = 0;
        n0     = 0;
        last_c = 0;
        for (int c = 1; c <= 80 && npulse < 5; c++) begin
            step();
            // Requester 0 scans 0..3: advance once its address reaches the ROM.
            if (gnt[0] && ROM_addr == req_addr[0 +: ADDR_W]) begin
                if (req_addr[0 +: ADDR_W] < 5'd3) req_addr[0 +: ADDR_W] = req_addr[0 +: ADDR_W] + 5'd1;
                else lock[0] = 1'b0;
            end
            if (rd_valid !== '0) begin
                exp_d = (exp_w[npulse] == 0) ? rom_mem[n0] : rom_mem[20];
                checks++; if (rd_valid !== onehot(exp_w[npulse])) begin errors++; $display("FAIL lock_rd_valid[%0d]: got %b expected %b", npulse, rd_valid, onehot(exp_w[npulse])); end
                checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL lock_rd_data[%0d]: got %h expected %h", npulse, rd_data, exp_d); end
                if (npulse > 0) begin
                    checks++; if (c - last_c != exp_gap[npulse-1]) begin errors++; $display("FAIL lock_spacing[%0d]: got %0d expected %0d", npulse, c - last_c, exp_gap[npulse-1]); end
                end
                if (exp_w[npulse] == 0) n0++;
                last_c = c;
                npulse++;
            end
        end
        checks++; if (npulse < 5) begin errors++; $display("FAIL lock_timeout: got %0d pulses expected 5", npulse); end
        req  = '0;
        lock = '0;
        step();
        step();
    endtask

    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) rom_mem[i] = DATA_W'($urandom);
        do_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_random();
        test_reset_mid();
        test_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
